// File: rtl/fifo_pack_nto1_pkg.sv
// fifo_pack_pkg: shared helpers and constants for the N-to-1 packing FIFO.
package fifo_pack_pkg;
  localparam int MAX_LANES = 16;
  localparam int DROP_CNT_W = 16;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic logic [4:0] popcount(input logic [MAX_LANES-1:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < MAX_LANES; i++) c = c + 5'(v[i]);
    return c;
  endfunction
endpackage

// File: rtl/fifo_pack_nto1_if.sv
// fifo_pack_nto1_if: write/read bus of the packing FIFO; FIFO_PACK_STATS_EN adds drop statistics.
interface fifo_pack_nto1_if #(
  parameter int LANES = 6,
  parameter int DATA_W = 12,
  parameter int DEPTH = 256
);
  import fifo_pack_pkg::*;
  localparam int CNT_W = clog2(DEPTH) + 1;
  logic w_en;
  logic [LANES*DATA_W-1:0] data_in;
  logic [LANES-1:0] valid_in;
  logic r_en;
  logic [DATA_W-1:0] data_out;
  logic valid_out;
  logic full;
  logic empty;
  logic [CNT_W-1:0] count;
`ifdef FIFO_PACK_STATS_EN
  logic [DROP_CNT_W-1:0] drop_cnt;
  logic ovf_sticky;
`endif
  modport master (
    output w_en, data_in, valid_in, r_en,
    input data_out, valid_out, full, empty, count
`ifdef FIFO_PACK_STATS_EN
    , input drop_cnt, ovf_sticky
`endif
  );
  modport slave (
    input w_en, data_in, valid_in, r_en,
    output data_out, valid_out, full, empty, count
`ifdef FIFO_PACK_STATS_EN
    , output drop_cnt, ovf_sticky
`endif
  );
endinterface

// File: rtl/fifo_pack_nto1_lane_compact.sv
// lane_compact: exclusive prefix-sum of lane valids giving each lane its packed slot offset.
module lane_compact import fifo_pack_pkg::*; #(
  parameter int LANES = 6,
  parameter int DATA_W = 12,
  localparam int OFF_W = clog2(LANES + 1)
) (
  input  logic [LANES*DATA_W-1:0] data_in,
  input  logic [LANES-1:0]        valid_in,
  output logic [OFF_W-1:0]        off [LANES],
  output logic [LANES-1:0]        we,
  output logic [DATA_W-1:0]       word [LANES],
  output logic [OFF_W-1:0]        n
);
  logic [OFF_W-1:0] acc;
  always_comb begin
    acc = '0;
    for (int i = 0; i < LANES; i++) begin
      off[i] = acc;
      word[i] = data_in[i*DATA_W +: DATA_W];
      acc = acc + OFF_W'(valid_in[i]);
    end
  end
  assign we = valid_in;
  assign n = OFF_W'(popcount(MAX_LANES'(valid_in)));
endmodule

// File: rtl/fifo_pack_nto1.sv
// fifo_pack_nto1: LANES-wide packing write, one-word registered read FIFO.
// Optional drop statistics enabled by FIFO_PACK_STATS_EN.
module fifo_pack_nto1 import fifo_pack_pkg::*; #(
  parameter int LANES = 6,
  parameter int DATA_W = 12,
  parameter int DEPTH = 256
) (
  input logic clk,
  input logic rst_n,
  fifo_pack_nto1_if.slave bus
);
  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OFF_W = clog2(LANES + 1);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0] w_ptr, r_ptr, cnt, free;
  logic [OFF_W-1:0] off [LANES];
  logic [DATA_W-1:0] word [LANES];
  logic [LANES-1:0] we;
  logic [OFF_W-1:0] n;
  logic [DATA_W-1:0] data_out;
  logic valid_out, full, empty, wr, rd;
  lane_compact #(.LANES(LANES), .DATA_W(DATA_W)) u_compact (
    .data_in(bus.data_in), .valid_in(bus.valid_in),
    .off(off), .we(we), .word(word), .n(n)
  );
  // Flags come from registered pointers only, so a same-cycle read gives no write credit
  assign cnt = w_ptr - r_ptr;
  assign free = CNT_W'(DEPTH) - cnt;
  assign full = free < CNT_W'(LANES);
  assign empty = cnt == '0;
  assign wr = bus.w_en & ~full;
  assign rd = bus.r_en & ~empty;
  always_ff @(posedge clk)
    if (wr)
      for (int i = 0; i < LANES; i++)
        if (we[i]) mem[w_ptr[PTR_W-1:0] + PTR_W'(off[i])] <= word[i];
  always_ff @(posedge clk)
    if (!rst_n) begin
      w_ptr <= '0;
      r_ptr <= '0;
      data_out <= '0;
      valid_out <= 1'b0;
    end else begin
      if (wr) w_ptr <= w_ptr + CNT_W'(n);
      if (rd) r_ptr <= r_ptr + CNT_W'(1);
      valid_out <= rd;
      data_out <= rd ? mem[r_ptr[PTR_W-1:0]] : '0;
    end
  assign bus.data_out = data_out;
  assign bus.valid_out = valid_out;
  assign bus.full = full;
  assign bus.empty = empty;
  assign bus.count = cnt;
`ifdef FIFO_PACK_STATS_EN
  logic [DROP_CNT_W-1:0] drop_cnt;
  logic ovf_sticky, drop;
  assign drop = bus.w_en & full & |bus.valid_in;
  always_ff @(posedge clk)
    if (!rst_n) begin
      drop_cnt <= '0;
      ovf_sticky <= 1'b0;
    end else if (drop) begin
      drop_cnt <= &drop_cnt ? drop_cnt : drop_cnt + DROP_CNT_W'(1);
      ovf_sticky <= 1'b1;
    end
  assign bus.drop_cnt = drop_cnt;
  assign bus.ovf_sticky = ovf_sticky;
`endif
endmodule

// File: tb/tb_fifo_pack_nto1.sv
// tb_fifo_pack_nto1: directed self-checking bench for the packing FIFO.
module tb_fifo_pack_nto1;
  localparam int LANES = 6;
  localparam int DATA_W = 12;
  localparam int DEPTH = 256;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [LANES*DATA_W-1:0] d;
  always #5 clk = ~clk;
  fifo_pack_nto1_if #(.LANES(LANES), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();
  fifo_pack_nto1 #(.LANES(LANES), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [LANES*DATA_W-1:0] seqd(input int base);
    logic [LANES*DATA_W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DATA_W +: DATA_W] = DATA_W'(base + i);
    return r;
  endfunction
  task automatic wr(input logic [LANES-1:0] v, input logic [LANES*DATA_W-1:0] dd);
    bus.w_en = 1'b1;
    bus.valid_in = v;
    bus.data_in = dd;
    tick();
    bus.w_en = 1'b0;
  endtask
  task automatic rd(input string tag, input int exp);
    bus.r_en = 1'b1;
    tick();
    bus.r_en = 1'b0;
    chk({tag, "_v"}, 32'(bus.valid_out), 1);
    chk({tag, "_d"}, 32'(bus.data_out), exp);
  endtask
  initial begin
    bus.w_en = 1'b0;
    bus.r_en = 1'b0;
    bus.valid_in = '0;
    bus.data_in = '0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_valid", 32'(bus.valid_out), 0);
    chk("rst_data", 32'(bus.data_out), 0);
`ifdef FIFO_PACK_STATS_EN
    chk("rst_drop", 32'(bus.drop_cnt), 0);
    chk("rst_ovf", 32'(bus.ovf_sticky), 0);
`endif
    // all six lanes, data 1..6
    wr(6'h3f, seqd(1));
    chk("w6_count", 32'(bus.count), 6);
    chk("w6_empty", 32'(bus.empty), 0);
    for (int i = 0; i < 6; i++) rd("w6_rd", i + 1);
    tick();
    chk("w6_idle_v", 32'(bus.valid_out), 0);
    chk("w6_idle_d", 32'(bus.data_out), 0);
    chk("w6_empty_after", 32'(bus.empty), 1);
    // sparse lanes 0/3/5
    d = seqd('h111);
    d[0*DATA_W +: DATA_W] = 12'hA;
    d[3*DATA_W +: DATA_W] = 12'hB;
    d[5*DATA_W +: DATA_W] = 12'hC;
    wr(6'b101001, d);
    chk("sparse_count", 32'(bus.count), 3);
    wr(6'b000000, seqd('h555));
    chk("zero_lane_noop", 32'(bus.count), 3);
    rd("sparse0", 'hA);
    rd("sparse1", 'hB);
    rd("sparse2", 'hC);
    chk("sparse_empty", 32'(bus.empty), 1);
    // reset to align pointers at 0, then fill to 251
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int j = 0; j < 41; j++) wr(6'h3f, seqd('h100 + 6 * j));
    chk("fill_246_full", 32'(bus.full), 0);
    wr(6'h1f, seqd('h100 + 246));
    chk("fill_count", 32'(bus.count), 251);
    chk("fill_full", 32'(bus.full), 1);
    for (int j = 0; j < 3; j++) begin
      wr(6'h3f, seqd('hE00));
      chk("drop_count", 32'(bus.count), 251);
    end
    wr(6'h00, seqd('hE00));
    chk("drop_zero_count", 32'(bus.count), 251);
`ifdef FIFO_PACK_STATS_EN
    chk("drop_cnt3", 32'(bus.drop_cnt), 3);
    chk("ovf_set", 32'(bus.ovf_sticky), 1);
`endif
    rd("fill_rd0", 'h100);
    chk("free6_count", 32'(bus.count), 250);
    chk("free6_full", 32'(bus.full), 0);
    d = seqd('h0);
    d[2*DATA_W +: DATA_W] = 12'h200;
    d[5*DATA_W +: DATA_W] = 12'h201;
    wr(6'b100100, d);
    chk("refill_count", 32'(bus.count), 252);
    chk("refill_full", 32'(bus.full), 1);
    bus.r_en = 1'b1;
    for (int k = 0; k < 252; k++) begin
      tick();
      chk("drain", 32'(bus.data_out), k < 250 ? 'h101 + k : 'h200 + (k - 250));
    end
    bus.r_en = 1'b0;
    tick();
    chk("drain_empty", 32'(bus.empty), 1);
    chk("drain_valid", 32'(bus.valid_out), 0);
    // w_ptr is 253: group straddles the end of memory
    wr(6'h3f, seqd('h300));
    chk("wrap_count", 32'(bus.count), 6);
    for (int i = 0; i < 6; i++) rd("wrap_rd", 'h300 + i);
    chk("wrap_empty", 32'(bus.empty), 1);
    // simultaneous read and write at count 2
    wr(6'h03, seqd('h400));
    chk("sim_pre_count", 32'(bus.count), 2);
    bus.w_en = 1'b1;
    bus.valid_in = 6'b001111;
    bus.data_in = seqd('h410);
    bus.r_en = 1'b1;
    tick();
    bus.w_en = 1'b0;
    chk("sim_count", 32'(bus.count), 5);
    chk("sim_valid", 32'(bus.valid_out), 1);
    chk("sim_data", 32'(bus.data_out), 'h400);
    tick();
    chk("sim_rd1", 32'(bus.data_out), 'h401);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("sim_rdn", 32'(bus.data_out), 'h410 + i);
    end
    bus.r_en = 1'b0;
    tick();
    chk("sim_empty", 32'(bus.empty), 1);
    // mid-burst reset at count 40
    for (int j = 0; j < 6; j++) wr(6'h3f, seqd('h500 + 6 * j));
    wr(6'h0f, seqd('h600));
    chk("mid_count", 32'(bus.count), 40);
`ifdef FIFO_PACK_STATS_EN
    chk("mid_drop", 32'(bus.drop_cnt), 3);
    chk("mid_ovf", 32'(bus.ovf_sticky), 1);
`endif
    bus.r_en = 1'b1;
    tick();
    chk("burst_rd", 32'(bus.data_out), 'h500);
    rst_n = 1'b0;
    bus.w_en = 1'b1;
    bus.valid_in = 6'h3f;
    bus.data_in = seqd('h700);
    tick();
    chk("mrst_count", 32'(bus.count), 0);
    chk("mrst_empty", 32'(bus.empty), 1);
    chk("mrst_valid", 32'(bus.valid_out), 0);
    chk("mrst_data", 32'(bus.data_out), 0);
`ifdef FIFO_PACK_STATS_EN
    chk("mrst_drop", 32'(bus.drop_cnt), 0);
    chk("mrst_ovf", 32'(bus.ovf_sticky), 0);
`endif
    rst_n = 1'b1;
    bus.w_en = 1'b0;
    bus.r_en = 1'b0;
    wr(6'b000001, seqd('h7AB));
    rd("post_rst", 'h7AB);
    chk("post_rst_empty", 32'(bus.empty), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
